// File: rtl/vic_wb_ctrl_pkg.sv
// Shared types for the victim-cache writeback controller: cache line, memory bus
// command and controller FSM state, plus the line-address helper.
package vic_wb_ctrl_pkg;

    localparam int NUM_SET_BITS = 6;
    localparam int NUM_TAG_BITS = 10;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } CACHE_LINE_T;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } wb_state_e;

    // Byte address of a line: {tag, set, 3'b000}, zero-extended.
    function automatic logic [63:0] line_addr(input logic [NUM_TAG_BITS-1:0] tag,
                                              input logic [NUM_SET_BITS-1:0] set_index);
        return 64'({tag, set_index, 3'b000});
    endfunction

endpackage

// File: rtl/vic_wb_ctrl_if.sv
// Memory-side bus between the writeback controller (master) and memory (slave).
// Handshake: the master holds command/addr/data stable while command != BUS_NONE;
// a nonzero mem2proc_response in a cycle means the command was accepted at that edge.
interface vic_wb_ctrl_if;
    import vic_wb_ctrl_pkg::*;

    BUS_COMMAND  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;

    modport master (
        output proc2mem_command,
        output proc2mem_addr,
        output proc2mem_data,
        input  mem2proc_response
    );

    modport slave (
        input  proc2mem_command,
        input  proc2mem_addr,
        input  proc2mem_data,
        output mem2proc_response
    );

endinterface

// File: rtl/vic_wb_ctrl_wb_fifo.sv
// Writeback buffer: circular FIFO of dirty victims with a parallel read port of
// every slot so the controller can search it for load forwarding.
module wb_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [63:0]             push_addr,
    input  logic [63:0]             push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [PTR_W-1:0]        head_ptr,
    output logic [63:0]             head_addr,
    output logic [63:0]             head_data,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [DEPTH-1:0][60:0]  entry_line,
    output logic [DEPTH-1:0][63:0]  entry_data
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [63:0]      addr_mem [DEPTH];
    logic [63:0]      data_mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_line[i] = addr_mem[i][63:3];
            entry_data[i] = data_mem[i];
        end
    end

    assign head_ptr  = rd_ptr;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/vic_wb_ctrl.sv
// Victim writeback controller: buffers dirty evictions, arbitrates line-fill loads
// against writebacks on the memory bus, and forwards loads that hit the buffer.
module vic_wb_ctrl
    import vic_wb_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fired_valid,
    input  CACHE_LINE_T             fired_victim,
    input  logic [NUM_SET_BITS-1:0] fired_set_index,
    output logic                    wb_stall,
    input  logic                    ld_req_valid,
    input  logic [63:0]             ld_req_addr,
    output logic                    ld_grant,
    output logic [3:0]              ld_mem_tag,
    output logic                    ld_fwd_valid,
    output logic [63:0]             ld_fwd_data,
    vic_wb_ctrl_if.master           mem,
    output wb_state_e               fsm_state
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    wb_state_e                     state;
    logic                          ld_pending;
    logic [63:0]                   ld_addr;
    logic                          mem_accept;
    logic                          store_accept;
    logic                          load_accept;
    logic                          push;
    logic                          full;
    logic                          empty;
    logic [PTR_W-1:0]              head_ptr;
    logic [63:0]                   head_addr;
    logic [63:0]                   head_data;
    logic [WB_DEPTH-1:0]           entry_valid;
    logic [WB_DEPTH-1:0][60:0]     entry_line;
    logic [WB_DEPTH-1:0][63:0]     entry_data;
    logic                          fwd_hit;
    logic [63:0]                   fwd_data;
    logic [PTR_W-1:0]              fwd_idx;

    assign mem_accept   = (mem.mem2proc_response != 4'd0);
    assign store_accept = (state == STORE) && mem_accept;
    assign load_accept  = (state == LOAD) && mem_accept;
    assign wb_stall     = full && !store_accept;
    assign push         = fired_valid && fired_victim.valid && fired_victim.dirty && !wb_stall;
    assign fsm_state    = state;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_addr   (line_addr(fired_victim.tag, fired_set_index)),
        .push_data   (fired_victim.data),
        .pop         (store_accept),
        .full        (full),
        .empty       (empty),
        .head_ptr    (head_ptr),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_line  (entry_line),
        .entry_data  (entry_data)
    );

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = head_ptr + PTR_W'(i);
            if (entry_valid[fwd_idx] && (entry_line[fwd_idx] == ld_req_addr[63:3])) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[fwd_idx];
            end
        end
    end

    assign ld_fwd_valid = ld_req_valid && !ld_pending && fwd_hit;
    assign ld_fwd_data  = fwd_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_pending <= 1'b0;
            ld_addr    <= '0;
        end else if (load_accept) begin
            ld_pending <= 1'b0;
        end else if (ld_req_valid && !ld_pending && !fwd_hit) begin
            ld_pending <= 1'b1;
            ld_addr    <= ld_req_addr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            mem.proc2mem_command <= BUS_NONE;
            mem.proc2mem_addr    <= '0;
            mem.proc2mem_data    <= '0;
            ld_grant             <= 1'b0;
            ld_mem_tag           <= '0;
        end else begin
            ld_grant <= 1'b0;
            case (state)
                IDLE: begin
                    if (full) begin
                        state                <= STORE;
                        mem.proc2mem_command <= BUS_STORE;
                        mem.proc2mem_addr    <= head_addr;
                        mem.proc2mem_data    <= head_data;
                    end else if (ld_pending) begin
                        state                <= LOAD;
                        mem.proc2mem_command <= BUS_LOAD;
                        mem.proc2mem_addr    <= ld_addr;
                        mem.proc2mem_data    <= '0;
                    end else if (!empty) begin
                        state                <= STORE;
                        mem.proc2mem_command <= BUS_STORE;
                        mem.proc2mem_addr    <= head_addr;
                        mem.proc2mem_data    <= head_data;
                    end
                end
                LOAD: begin
                    if (mem_accept) begin
                        state                <= IDLE;
                        mem.proc2mem_command <= BUS_NONE;
                        mem.proc2mem_addr    <= '0;
                        ld_grant             <= 1'b1;
                        ld_mem_tag           <= mem.mem2proc_response;
                    end
                end
                STORE: begin
                    if (mem_accept) begin
                        state                <= IDLE;
                        mem.proc2mem_command <= BUS_NONE;
                        mem.proc2mem_addr    <= '0;
                        mem.proc2mem_data    <= '0;
                    end
                end
                default: begin
                    state                <= IDLE;
                    mem.proc2mem_command <= BUS_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vic_wb_ctrl.sv
// Bench for vic_wb_ctrl: eviction table, writeback/load/forwarding sequences and
// a store scoreboard checked against the memory bus.
module tb_vic_wb_ctrl;
    import vic_wb_ctrl_pkg::*;

    logic                    clock;
    logic                    reset;
    logic                    fired_valid;
    CACHE_LINE_T             fired_victim;
    logic [NUM_SET_BITS-1:0] fired_set_index;
    logic                    wb_stall;
    logic                    ld_req_valid;
    logic [63:0]             ld_req_addr;
    logic                    ld_grant;
    logic [3:0]              ld_mem_tag;
    logic                    ld_fwd_valid;
    logic [63:0]             ld_fwd_data;
    wb_state_e               fsm_state;

    vic_wb_ctrl_if mem_if();

    vic_wb_ctrl #(.WB_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .fired_valid     (fired_valid),
        .fired_victim    (fired_victim),
        .fired_set_index (fired_set_index),
        .wb_stall        (wb_stall),
        .ld_req_valid    (ld_req_valid),
        .ld_req_addr     (ld_req_addr),
        .ld_grant        (ld_grant),
        .ld_mem_tag      (ld_mem_tag),
        .ld_fwd_valid    (ld_fwd_valid),
        .ld_fwd_data     (ld_fwd_data),
        .mem             (mem_if.master),
        .fsm_state       (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int load_cycles  = 0;
    int grant_cycles = 0;
    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;

    typedef struct {
        logic                    fv;
        logic                    vb;
        logic                    db;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [NUM_SET_BITS-1:0] set_i;
        logic [63:0]             data;
        logic                    exp_stall;
        logic                    exp_acc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_addr(input logic [NUM_TAG_BITS-1:0] t,
                                             input logic [NUM_SET_BITS-1:0] s);
        return (64'(t) << (NUM_SET_BITS + 3)) | (64'(s) << 3);
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // driver: one eviction cycle; expected stall and acceptance come from the caller
    task automatic push_line(input logic fv, input logic vb, input logic db,
                             input logic [NUM_TAG_BITS-1:0] t, input logic [NUM_SET_BITS-1:0] s,
                             input logic [63:0] d, input logic exp_stall, input logic exp_acc);
        fired_valid     = fv;
        fired_victim    = '{valid: vb, dirty: db, tag: t, data: d};
        fired_set_index = s;
        @(negedge clock);
        check("wb_stall_at_push", 64'(wb_stall), 64'(exp_stall));
        if (exp_acc) exp_q.push_back({ref_addr(t, s), d});
        cyc();
        fired_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        mem_if.mem2proc_response = 4'd1;
        while (exp_q.size() != 0 && n < limit) begin
            cyc();
            n++;
        end
        mem_if.mem2proc_response = 4'd0;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard / bus monitor
    always @(negedge clock) begin
        if (reset) begin
            if (mem_if.proc2mem_command == BUS_LOAD) load_cycles++;
            if (ld_grant) grant_cycles++;
            if (mem_if.proc2mem_command == BUS_STORE && mem_if.mem2proc_response != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("store_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("store_addr", mem_if.proc2mem_addr, mon_exp[127:64]);
                    check("store_data", mem_if.proc2mem_data, mon_exp[63:0]);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 10'd10, 6'd1, 64'h1000, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 10'd11, 6'd1, 64'h1001, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 10'd12, 6'd1, 64'h1002, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 10'd13, 6'd1, 64'h1003, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 10'd14, 6'd2, 64'h1004, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 10'd15, 6'd3, 64'h1005, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 10'd16, 6'd4, 64'h1006, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 10'd17, 6'd5, 64'h1007, 1'b1, 1'b0};

        reset                    = 1'b0;
        fired_valid              = 1'b0;
        fired_victim             = '0;
        fired_set_index          = '0;
        ld_req_valid             = 1'b0;
        ld_req_addr              = '0;
        mem_if.mem2proc_response = 4'd0;

        // reset state
        #12;
        check("rst_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
        check("rst_addr", mem_if.proc2mem_addr, 64'd0);
        check("rst_data", mem_if.proc2mem_data, 64'd0);
        check("rst_grant", 64'(ld_grant), 64'd0);
        check("rst_fwd", 64'(ld_fwd_valid), 64'd0);
        check("rst_stall", 64'(wb_stall), 64'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // clean victim is dropped
        push_line(1'b1, 1'b1, 1'b0, 10'd7, 6'd1, 64'h77, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("clean_cmd_none", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
            cyc();
        end

        // single eviction: held 4 cycles, accepted on the 4th
        push_line(1'b1, 1'b1, 1'b1, 10'd5, 6'd2, 64'hAB, 1'b0, 1'b1);
        @(negedge clock);
        check("single_idle_first", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
        cyc();
        for (int k = 0; k < 4; k++) begin
            mem_if.mem2proc_response = (k == 3) ? 4'd1 : 4'd0;
            @(negedge clock);
            check("single_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_STORE));
            check("single_addr", mem_if.proc2mem_addr, 64'hA10);
            check("single_data", mem_if.proc2mem_data, 64'hAB);
            cyc();
        end
        mem_if.mem2proc_response = 4'd0;
        @(negedge clock);
        check("single_done_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
        cyc();
        @(negedge clock);
        check("single_empty_idle", 64'(fsm_state), 64'(IDLE));
        cyc();

        // eviction table with memory refusing: fill to full, 5th push stalled
        for (int v = 0; v < 8; v++)
            push_line(vecs[v].fv, vecs[v].vb, vecs[v].db, vecs[v].tag, vecs[v].set_i,
                      vecs[v].data, vecs[v].exp_stall, vecs[v].exp_acc);
        // acceptance frees the stall in the same cycle; retried push lands
        mem_if.mem2proc_response = 4'd1;
        push_line(1'b1, 1'b1, 1'b1, 10'd17, 6'd5, 64'h1007, 1'b0, 1'b1);
        mem_if.mem2proc_response = 4'd0;
        @(negedge clock);
        check("full_after_push_pop", 64'(wb_stall), 64'd1);
        cyc();
        drain(40);

        // forwarding: youngest match wins, no load issued
        push_line(1'b1, 1'b1, 1'b1, 10'd20, 6'd3, 64'h111, 1'b0, 1'b1);
        push_line(1'b1, 1'b1, 1'b1, 10'd21, 6'd4, 64'h222, 1'b0, 1'b1);
        push_line(1'b1, 1'b1, 1'b1, 10'd20, 6'd3, 64'h333, 1'b0, 1'b1);
        ld_req_valid = 1'b1;
        ld_req_addr  = ref_addr(10'd20, 6'd3) | 64'h5;
        @(negedge clock);
        check("fwd_valid_young", 64'(ld_fwd_valid), 64'd1);
        check("fwd_data_young", ld_fwd_data, 64'h333);
        ld_req_addr = ref_addr(10'd22, 6'd3);
        #1;
        check("fwd_miss", 64'(ld_fwd_valid), 64'd0);
        ld_req_addr = ref_addr(10'd21, 6'd4);
        #1;
        check("fwd_valid_b", 64'(ld_fwd_valid), 64'd1);
        check("fwd_data_b", ld_fwd_data, 64'h222);
        cyc();
        ld_req_valid = 1'b0;
        drain(40);

        // load priority over buffered stores
        ld_req_valid = 1'b1;
        ld_req_addr  = ref_addr(10'd30, 6'd7);
        push_line(1'b1, 1'b1, 1'b1, 10'd31, 6'd1, 64'hC0C0, 1'b0, 1'b1);
        ld_req_valid = 1'b0;
        push_line(1'b1, 1'b1, 1'b1, 10'd32, 6'd2, 64'hD0D0, 1'b0, 1'b1);
        check("ld_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_LOAD));
        check("ld_addr", mem_if.proc2mem_addr, ref_addr(10'd30, 6'd7));
        mem_if.mem2proc_response = 4'd3;
        cyc();
        mem_if.mem2proc_response = 4'd0;
        @(negedge clock);
        check("ld_grant", 64'(ld_grant), 64'd1);
        check("ld_tag", 64'(ld_mem_tag), 64'd3);
        check("ld_cmd_after", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
        cyc();
        @(negedge clock);
        check("ld_grant_drop", 64'(ld_grant), 64'd0);
        check("store_after_load", 64'(mem_if.proc2mem_command), 64'(BUS_STORE));
        check("store_after_load_addr", mem_if.proc2mem_addr, ref_addr(10'd31, 6'd1));
        cyc();
        drain(40);

        // reset mid-STORE with full buffer and a pending load
        push_line(1'b1, 1'b1, 1'b1, 10'd40, 6'd1, 64'h4001, 1'b0, 1'b1);
        ld_req_valid = 1'b1;
        ld_req_addr  = ref_addr(10'd50, 6'd9);
        push_line(1'b1, 1'b1, 1'b1, 10'd41, 6'd1, 64'h4002, 1'b0, 1'b1);
        ld_req_valid = 1'b0;
        push_line(1'b1, 1'b1, 1'b1, 10'd42, 6'd1, 64'h4003, 1'b0, 1'b1);
        push_line(1'b1, 1'b1, 1'b1, 10'd43, 6'd1, 64'h4004, 1'b0, 1'b1);
        @(negedge clock);
        check("pre_rst_stall", 64'(wb_stall), 64'd1);
        check("pre_rst_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_STORE));
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
        check("mid_rst_addr", mem_if.proc2mem_addr, 64'd0);
        check("mid_rst_stall", 64'(wb_stall), 64'd0);
        check("mid_rst_state", 64'(fsm_state), 64'(IDLE));
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("post_rst_cmd", 64'(mem_if.proc2mem_command), 64'(BUS_NONE));
            check("post_rst_stall", 64'(wb_stall), 64'd0);
            cyc();
        end

        // final report
        check("final_exp_q", 64'(exp_q.size()), 64'd0);
        check("grant_pulses", 64'(grant_cycles), 64'd1);
        check("load_cmd_cycles", 64'(load_cycles), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vic_wb_ctrl.md
VIC_WB_CTRL -- requirements
Module: vic_wb_ctrl

Interface
- REQ-001 SHALL have parameter WB_DEPTH, default 4, writeback buffer entries (power of 2, >=2).
- REQ-002 SHALL have ports in this order:
  - clock  in  1  system clock.
  - reset  in  1  asynchronous, active-low reset.
- REQ-003 SHALL have fired_valid  in  1  victim evicted from vic_cache this cycle.
- REQ-004 SHALL have fired_victim  in  CACHE_LINE_T  evicted line (valid, dirty, tag, 64-bit data).
- REQ-005 SHALL have fired_set_index  in  NUM_SET_BITS  set of evicted line.
- REQ-006 SHALL have wb_stall  out  1  buffer cannot accept a push this cycle; vic_cache holds evictions.
- REQ-007 SHALL have ld_req_valid / ld_req_addr  in  1 / 64  line-fill request from the cache miss path.
- REQ-008 SHALL have ld_grant  out  1  load accepted by memory; ld_mem_tag  out  4  its tag.
- REQ-009 SHALL have ld_fwd_valid / ld_fwd_data  out  1 / 64  load satisfied from the buffer.
- REQ-010 SHALL have proc2mem_command  out  BUS_COMMAND  BUS_NONE/BUS_LOAD/BUS_STORE.
- REQ-011 SHALL have proc2mem_addr / proc2mem_data  out  64 / 64  address and store data.
- REQ-012 SHALL have mem2proc_response  in  4  nonzero = command accepted this cycle.

Function
- REQ-013 SHALL push fired_victim when fired_valid && valid && dirty && !wb_stall; clean or invalid victims are discarded.
- REQ-014 SHALL form the entry address as {tag, fired_set_index, 3'b000}, zero-extended to 64 bits.
- REQ-015 SHALL drive wb_stall = full && !(store accepted this cycle).
- REQ-016 SHALL implement an FSM with states IDLE, LOAD and STORE.
- REQ-017 In IDLE, SHALL select the next state by this priority: buffer full -> STORE; load pending and not forwarded -> LOAD; buffer non-empty -> STORE; else remain IDLE.
- REQ-018 SHALL drive BUS_LOAD only in LOAD and BUS_STORE only in STORE; in IDLE the command SHALL be BUS_NONE.
- REQ-019 SHALL hold command, address and data constant until mem2proc_response != 0; no preemption.
- REQ-020 STORE SHALL send the oldest (head) entry and pop it on acceptance; LOAD SHALL send the latched load address.
- REQ-021 On acceptance, SHALL pulse ld_grant for exactly one cycle with ld_mem_tag = mem2proc_response, then return to IDLE.
- REQ-022 SHALL latch a load request only when no load is pending; further requests SHALL be ignored until ld_grant or ld_fwd_valid.
- REQ-023 When ld_req_addr[63:3] matches a valid entry's address, SHALL assert ld_fwd_valid combinationally in the same cycle, with the youngest match's data.
- REQ-024 A forwarded load SHALL NOT be latched and SHALL NOT issue BUS_LOAD.
- REQ-025 Simultaneous push and pop SHALL both take effect, and count SHALL be unchanged.
- REQ-026 Pointers SHALL wrap modulo WB_DEPTH; full/empty SHALL be derived from a count of width clog2(WB_DEPTH)+1.

Reset
- REQ-027 On reset low, asynchronously:
  - buffer emptied, all entry valid bits 0;
  - pointers and count 0;
  - FSM in IDLE with no load pending.
- REQ-028 While reset is low, outputs SHALL be: proc2mem_command=BUS_NONE, addr/data=0, ld_grant=0, ld_fwd_valid=0, wb_stall=0.
- REQ-029 Reset asserted mid-transaction SHALL abandon the command; the pending load SHALL be lost and re-requested by the miss path.

Structure
- REQ-030 CACHE_LINE_T, BUS_COMMAND, NUM_SET_BITS and NUM_TAG_BITS SHALL come from the shared system package; the FSM state enum SHALL be declared in the same package.
- REQ-031 The buffer SHALL be a sub-module wb_fifo (push/pop/full/empty plus parallel entry read port for the forwarding CAM); the FSM and arbitration SHALL stay in vic_wb_ctrl.

Verification
- REQ-032 Reset scenario: reset=0 mid-STORE -> next cycle command=BUS_NONE, wb_stall=0, buffer empty.
- REQ-033 Single eviction scenario: push one dirty line (tag=5, set=2, data=0xAB), response 0 for 3 cycles then 1 -> BUS_STORE at addr 0x...(5,2,000) held 4 cycles, then buffer empty.
- REQ-034 Fill scenario: push 4 dirty lines with memory refusing -> wb_stall=1 and a 5th push ignored; one acceptance -> wb_stall deasserts in the same cycle and the 5th push succeeds.
- REQ-035 Load priority scenario: buffer holding 2 entries plus a load to a non-matching address -> BUS_LOAD first; on response 3, ld_grant pulses once with ld_mem_tag=3, then BUS_STORE.
- REQ-036 Forwarding scenario: load address equal to a buffered line -> ld_fwd_valid=1 with that data in the same cycle, no BUS_LOAD issued.
- REQ-037 Clean victim scenario: push with dirty=0 -> no push, command stays BUS_NONE.
